dmem_mmio_responder: RTL and testbench
======================================

# dmem_mmio_responder

Responder side of the processor's data-memory port. It services every `address_dmem`/`data`/`wren` request from the processor core with a synchronous word RAM in the low address region and a small memory-mapped I/O register page at the top of the 12-bit word space. It replaces the bare `dmem` instance at the top level and returns `q_dmem` with one-cycle registered read latency.

## Interface
- `DEPTH`, 1024: number of 32-bit RAM words at addresses 0..DEPTH-1; legal range 1..3840.
- `LED_W`, 16: width of the LED output register.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `address_dmem`  in  12  word address from the processor.
- `data`  in  32  write data.
- `wren`  in  1  write enable, sampled each rising edge.
- `q_dmem`  out  32  registered read data.
- `led`  out  LED_W  LED register contents.
- `irq`  out  1  timer-match interrupt pending (status bit 0).
- `bus_err`  out  1  sticky unmapped-access flag (status bit 1).

## Operation
- Address decode:
  - RAM: 0..DEPTH-1.
  - Hole: DEPTH..0xEFF.
  - MMIO page: 0xF00..0xFFF.
- RAM:
  - A write stores `data` on the edge.
  - A read returns the stored word.
  - Contents are not cleared by reset.
- Hole:
  - Reads return 0.
  - Writes are ignored.
  - Any access with `wren` = 1, or any read, sets `bus_err`.
- MMIO registers. Unlisted page offsets read 0, ignore writes, and do not set `bus_err`.
  - 0xF00 LED: R/W. The low LED_W bits are stored. Reads are zero-extended.
  - 0xF01 CYCLE: free-running 32-bit counter, +1 every clock, wraps 0xFFFFFFFF -> 0. A write loads `data`, and the counter increments from that value on the following edge.
  - 0xF02 CMP: R/W 32-bit compare value. When CMP != 0 and CYCLE == CMP, `irq` is set.
  - 0xF03 STATUS: bit0 = `irq`, bit1 = `bus_err`, other bits read 0. Writes are write-1-to-clear per bit.
- Simultaneous events:
  - Set and W1C on the same edge: set wins, so the bit stays 1.
  - CYCLE write and CMP match on the same edge: the match is evaluated on the pre-write CYCLE value.
- Reset values:
  - `q_dmem` = 0, LED = 0, CYCLE = 0, CMP = 0, `irq` = 0, `bus_err` = 0.
  - Assertion mid-access aborts the access. A RAM write on that edge is not guaranteed; all registers go to reset values immediately (asynchronously).

## Timing
- Read latency is 1 cycle: the address presented before edge N appears on `q_dmem` after edge N and holds until the next edge.
- Write-first: if `wren` = 1 on edge N, `q_dmem` after edge N shows the newly written value.
  - RAM, LED, CMP: the value as stored (LED masked to LED_W).
  - CYCLE: the loaded value.
  - STATUS: the post-clear value.
- A read of CYCLE returns the counter value before that edge's increment.
- `led`, `irq`, `bus_err` are registered outputs that change only on edges (or on reset).
- Back-to-back accesses every cycle are supported with no stall. There is no busy or ready signal.

## Test plan
- Reset, then write 0xDEADBEEF to 0x005, then read 0x005 -> `q_dmem` = 0xDEADBEEF one cycle after the read edge. A write-cycle readback shows the same value. Address 0x006 reads unchanged data.
- Write 0x0001ABCD to 0xF00 (LED_W = 16) -> `led` = 0xABCD. Reading 0xF00 returns 0x0000ABCD.
- Write 0xFFFFFFFE to 0xF01, then idle 3 cycles and read 0xF01 -> the value has wrapped through 0xFFFFFFFF to a small count (exactly 0x00000001 after the load plus 3 increments, allowing for read-before-increment).
- Write CMP = 20 after reset -> `irq` rises when CYCLE reaches 20.
  - Writing 0x1 to 0xF03 clears it.
  - If the clear coincides with a new match, `irq` stays 1.
- Read address 0x800 (DEPTH = 1024) -> `q_dmem` = 0 and `bus_err` = 1. It stays 1 after later legal accesses. Writing 0x2 to 0xF03 clears it.
- Drive `reset` low mid-stream with LED, CMP and flags set -> all outputs are 0 immediately, without waiting for a clock edge. RAM data written before reset is still readable after `reset` returns high.

Source files
------------

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-memory responder for the processor core.
// Word RAM at 0..DEPTH-1, unmapped hole up to 0xEFF, MMIO page at 0xF00..0xFFF
// (LED, free-running CYCLE counter, CMP compare, STATUS with W1C flags).
// Every cycle is an access; q_dmem is registered with write-first readback.
module dmem_mmio_responder #(
   parameter int DEPTH = 1024,
   parameter int LED_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [11:0]      address_dmem,
   input  logic [31:0]      data,
   input  logic             wren,
   output logic [31:0]      q_dmem,
   output logic [LED_W-1:0] led,
   output logic             irq,
   output logic             bus_err
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [12:0] RAM_TOP = 13'(DEPTH);

   logic [31:0]   mem [0:DEPTH-1];
   logic [31:0]   cycle, cmp;
   logic [AW-1:0] ram_idx;
   logic          is_ram, is_mmio, is_hole;
   logic          sel_led, sel_cyc, sel_cmp, sel_stat;
   logic          match;
   logic          irq_nxt, berr_nxt;
   logic [31:0]   cycle_nxt, q_nxt;

   assign ram_idx  = address_dmem[AW-1:0];
   assign is_ram   = {1'b0, address_dmem} < RAM_TOP;
   assign is_mmio  = (address_dmem[11:8] == 4'hF);
   // Every access in the hole is an error, read or write alike.
   assign is_hole  = !is_ram && !is_mmio;
   assign sel_led  = is_mmio && (address_dmem[7:0] == 8'h00);
   assign sel_cyc  = is_mmio && (address_dmem[7:0] == 8'h01);
   assign sel_cmp  = is_mmio && (address_dmem[7:0] == 8'h02);
   assign sel_stat = is_mmio && (address_dmem[7:0] == 8'h03);

   // Match uses the pre-write counter; set has priority over W1C.
   assign match     = (cmp != 32'd0) && (cycle == cmp);
   assign irq_nxt   = (irq & ~(wren & sel_stat & data[0])) | match;
   assign berr_nxt  = (bus_err & ~(wren & sel_stat & data[1])) | is_hole;
   assign cycle_nxt = (wren && sel_cyc) ? data : cycle + 32'd1;

   // Read mux: write-first value on a write, current contents otherwise.
   always_comb begin
      q_nxt = 32'd0;
      if (is_ram)        q_nxt = wren ? data : mem[ram_idx];
      else if (sel_led)  q_nxt = wren ? 32'(data[LED_W-1:0]) : 32'(led);
      else if (sel_cyc)  q_nxt = wren ? data : cycle;
      else if (sel_cmp)  q_nxt = wren ? data : cmp;
      else if (sel_stat) q_nxt = wren ? {30'd0, berr_nxt, irq_nxt} : {30'd0, bus_err, irq};
   end

   // RAM array: no reset, contents survive reset.
   always_ff @(posedge clock) begin
      if (wren && is_ram) mem[ram_idx] <= data;
   end

   // Registered outputs and MMIO state, asynchronously reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         q_dmem  <= '0;
         led     <= '0;
         cycle   <= '0;
         cmp     <= '0;
         irq     <= 1'b0;
         bus_err <= 1'b0;
      end else begin
         q_dmem  <= q_nxt;
         cycle   <= cycle_nxt;
         irq     <= irq_nxt;
         bus_err <= berr_nxt;
         if (wren && sel_led) led <= data[LED_W-1:0];
         if (wren && sel_cmp) cmp <= data;
      end
   end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: table of RAM/LED/hole vectors plus
// hand sequences for counter wrap, compare interrupt, W1C races and reset.
module tb_dmem_mmio_responder;

   logic        clock = 1'b0;
   logic        reset;
   logic [11:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic [15:0] led;
   logic        irq, bus_err;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] eq;
      logic [15:0] eled;
      logic        eberr;
   } vec_t;
   vec_t vt[$];

   dmem_mmio_responder #(.DEPTH(1024), .LED_W(16)) dut (
      .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
      .wren(wren), .q_dmem(q_dmem), .led(led), .irq(irq), .bus_err(bus_err)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endfunction

   // One access: drive, push expected readback, pop and compare after the edge.
   task automatic cyc(input logic [11:0] a, input logic [31:0] d, input logic we,
                      input logic [31:0] eq, input string name);
      logic [31:0] e;
      address_dmem = a; data = d; wren = we;
      exp_q.push_back(eq);
      @(posedge clock); #1;
      if (exp_q.size() == 0) begin
         chk({name, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk(name, q_dmem, e);
      end
      wren = 1'b0;
   endtask

   initial begin
      reset = 1'b0; address_dmem = 12'hF04; data = '0; wren = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_q", q_dmem, 32'd0);
      chk("rst_led", 32'(led), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_berr", 32'(bus_err), 32'd0);
      reset = 1'b1;

      // addr, data, wren, exp_q, exp_led, exp_bus_err
      vt.push_back('{12'h006, 32'h12345678, 1'b1, 32'h12345678, 16'h0000, 1'b0});
      vt.push_back('{12'h005, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 16'h0000, 1'b0});
      vt.push_back('{12'h005, 32'h00000000, 1'b0, 32'hDEADBEEF, 16'h0000, 1'b0});
      vt.push_back('{12'h006, 32'h00000000, 1'b0, 32'h12345678, 16'h0000, 1'b0});
      vt.push_back('{12'h3FF, 32'hAAAA5555, 1'b1, 32'hAAAA5555, 16'h0000, 1'b0});
      vt.push_back('{12'h3FF, 32'h00000000, 1'b0, 32'hAAAA5555, 16'h0000, 1'b0});
      vt.push_back('{12'hF00, 32'h0001ABCD, 1'b1, 32'h0000ABCD, 16'hABCD, 1'b0});
      vt.push_back('{12'hF00, 32'h00000000, 1'b0, 32'h0000ABCD, 16'hABCD, 1'b0});
      vt.push_back('{12'hF04, 32'h00000000, 1'b0, 32'h00000000, 16'hABCD, 1'b0});
      vt.push_back('{12'hF05, 32'hFFFFFFFF, 1'b1, 32'h00000000, 16'hABCD, 1'b0});
      vt.push_back('{12'h400, 32'h00000000, 1'b0, 32'h00000000, 16'hABCD, 1'b1});
      vt.push_back('{12'h005, 32'h00000000, 1'b0, 32'hDEADBEEF, 16'hABCD, 1'b1});
      vt.push_back('{12'hF03, 32'h00000002, 1'b1, 32'h00000000, 16'hABCD, 1'b0});
      vt.push_back('{12'hEFF, 32'h11111111, 1'b1, 32'h00000000, 16'hABCD, 1'b1});
      vt.push_back('{12'hF03, 32'h00000000, 1'b0, 32'h00000002, 16'hABCD, 1'b1});
      vt.push_back('{12'hF03, 32'h00000002, 1'b1, 32'h00000000, 16'hABCD, 1'b0});
      vt.push_back('{12'h3FF, 32'h00000000, 1'b0, 32'hAAAA5555, 16'hABCD, 1'b0});

      for (int i = 0; i < vt.size(); i++) begin
         cyc(vt[i].addr, vt[i].wdata, vt[i].we, vt[i].eq, $sformatf("vec%0d_q", i));
         chk($sformatf("vec%0d_led", i), 32'(led), 32'(vt[i].eled));
         chk($sformatf("vec%0d_berr", i), 32'(bus_err), 32'(vt[i].eberr));
      end

      // Counter wrap: load, three increments, read shows pre-increment value.
      cyc(12'hF01, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFE, "cyc_load");
      repeat (3) cyc(12'hF04, 32'd0, 1'b0, 32'd0, "idle");
      cyc(12'hF01, 32'd0, 1'b0, 32'h00000001, "cyc_wrap");

      // Compare interrupt: CYCLE=0 on E0, CMP=20 on E1, match on edge 21.
      cyc(12'hF01, 32'd0, 1'b1, 32'd0, "cyc_zero");
      cyc(12'hF02, 32'd20, 1'b1, 32'd20, "cmp_wr");
      chk("irq_pre", 32'(irq), 32'd0);
      for (int k = 2; k <= 21; k++) begin
         cyc(12'hF04, 32'd0, 1'b0, 32'd0, "idle");
         chk($sformatf("irq_k%0d", k), 32'(irq), (k >= 21) ? 32'd1 : 32'd0);
      end
      cyc(12'hF03, 32'd0, 1'b0, 32'd1, "stat_irq");
      cyc(12'hF03, 32'd1, 1'b1, 32'd0, "irq_clr_q");
      chk("irq_clr", 32'(irq), 32'd0);

      // Clear coinciding with a new match: set wins.
      cyc(12'hF01, 32'd18, 1'b1, 32'd18, "cyc18");
      cyc(12'hF04, 32'd0, 1'b0, 32'd0, "idle");
      cyc(12'hF04, 32'd0, 1'b0, 32'd0, "idle");
      chk("irq_before_race", 32'(irq), 32'd0);
      cyc(12'hF03, 32'd1, 1'b1, 32'd1, "race_q");
      chk("irq_race", 32'(irq), 32'd1);
      cyc(12'hF03, 32'd1, 1'b1, 32'd0, "irq_clr2_q");
      chk("irq_clr2", 32'(irq), 32'd0);

      // Sticky bus error from 0x800.
      cyc(12'h800, 32'd0, 1'b0, 32'd0, "hole_rd");
      chk("berr_set", 32'(bus_err), 32'd1);
      cyc(12'h005, 32'd0, 1'b0, 32'hDEADBEEF, "ram_after_hole");
      cyc(12'hF00, 32'd0, 1'b0, 32'h0000ABCD, "led_after_hole");
      chk("berr_sticky", 32'(bus_err), 32'd1);
      cyc(12'hF03, 32'd2, 1'b1, 32'd0, "berr_clr_q");
      chk("berr_clr", 32'(bus_err), 32'd0);

      // Mid-cycle reset with LED, CMP, irq and bus_err all set.
      cyc(12'hF02, 32'd40, 1'b1, 32'd40, "cmp40");
      cyc(12'hF01, 32'd40, 1'b1, 32'd40, "cyc40");
      cyc(12'h900, 32'd0, 1'b0, 32'd0, "hole2");
      chk("pre_rst_irq", 32'(irq), 32'd1);
      chk("pre_rst_berr", 32'(bus_err), 32'd1);
      address_dmem = 12'hF04;
      @(posedge clock); #3;
      reset = 1'b0;
      #1;
      chk("arst_q", q_dmem, 32'd0);
      chk("arst_led", 32'(led), 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      chk("arst_berr", 32'(bus_err), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      cyc(12'h005, 32'd0, 1'b0, 32'hDEADBEEF, "ram_kept");
      cyc(12'hF02, 32'd0, 1'b0, 32'd0, "cmp_rst");
      cyc(12'hF00, 32'd0, 1'b0, 32'd0, "led_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
